// File: rtl/uart_tx_fifo.sv
// UART transmitter with runtime baud divisor, optional parity, 1/2 stop bits
// and a small write FIFO so queued words go out back-to-back.
module uart_tx_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DIV_WIDTH  = 16,
    parameter int unsigned FIFO_AW    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIV_WIDTH-1:0]  div,
    input  logic                  parity_en,
    input  logic                  parity_odd,
    input  logic                  two_stop,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  overflow,
    output logic [FIFO_AW:0]      count,
    output logic                  busy,
    output logic                  tx
);

    localparam int unsigned DEPTH = 2 ** FIFO_AW;
    localparam int unsigned BIT_W = $clog2(DATA_WIDTH);
    localparam logic [FIFO_AW:0]     PTR_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
    localparam logic [DIV_WIDTH-1:0] DIV_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [BIT_W-1:0]     BIT_ONE  = {{(BIT_W-1){1'b0}}, 1'b1};
    localparam logic [BIT_W-1:0]     BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [FIFO_AW:0]      wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0]      rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]      count_d;
    logic                  overflow_q, overflow_d;

    state_e                state_q, state_d;
    logic [DIV_WIDTH-1:0]  timer_q, timer_d;
    logic [DIV_WIDTH-1:0]  div_q, div_d;
    logic                  parity_en_q, parity_en_d;
    logic                  two_stop_q, two_stop_d;
    logic                  par_q, par_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]      bit_idx_q, bit_idx_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;

    logic                  empty;
    logic                  full_w;
    logic                  push;
    logic                  pop;
    logic                  start_frame;
    logic                  tick;
    logic [DATA_WIDTH-1:0] head;

    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full_w = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                    (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    assign push   = wr_en && !full_w;
    assign head   = mem_q[rd_ptr_q[FIFO_AW-1:0]];
    assign tick   = (timer_q == div_q);

    assign full     = full_w;
    assign overflow = overflow_q;
    assign count    = wr_ptr_q - rd_ptr_q;
    assign busy     = busy_q;
    assign tx       = tx_q;

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        overflow_d = overflow_q || (wr_en && full_w);
        if (push) begin
            mem_d[wr_ptr_q[FIFO_AW-1:0]] = wr_data;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        rd_ptr_d = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = tick ? '0 : (timer_q + DIV_ONE);
        div_d       = div_q;
        parity_en_d = parity_en_q;
        two_stop_d  = two_stop_q;
        par_d       = par_q;
        shift_d     = shift_q;
        bit_idx_d   = bit_idx_q;
        stop_cnt_d  = stop_cnt_q;
        start_frame = 1'b0;
        pop         = 1'b0;

        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (!empty) start_frame = 1'b1;
            end
            S_START: begin
                if (tick) state_d = S_DATA;
            end
            S_DATA: begin
                if (tick) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + BIT_ONE;
                    if (bit_idx_q == BIT_LAST) begin
                        state_d    = parity_en_q ? S_PARITY : S_STOP;
                        stop_cnt_d = 1'b0;
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    state_d    = S_STOP;
                    stop_cnt_d = 1'b0;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (two_stop_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else if (!empty) begin
                        start_frame = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Shared by IDLE and end-of-STOP so both paths latch config identically.
        if (start_frame) begin
            pop         = 1'b1;
            state_d     = S_START;
            timer_d     = '0;
            shift_d     = head;
            bit_idx_d   = '0;
            stop_cnt_d  = 1'b0;
            div_d       = div;
            parity_en_d = parity_en;
            two_stop_d  = two_stop;
            par_d       = (^head) ^ parity_odd;
        end
    end

    // tx is registered from the current state, so the line lags the FSM by one
    // cycle; busy gets the same one-cycle tail to cover the last stop cycle.
    always_comb begin
        count_d = wr_ptr_d - rd_ptr_d;
        busy_d  = (state_d != S_IDLE) || (count_d != '0) || (state_q != S_IDLE);
        case (state_q)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_q[0];
            S_PARITY: tx_d = par_q;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            state_q     <= S_IDLE;
            timer_q     <= '0;
            div_q       <= '0;
            parity_en_q <= 1'b0;
            two_stop_q  <= 1'b0;
            par_q       <= 1'b0;
            shift_q     <= '0;
            bit_idx_q   <= '0;
            stop_cnt_q  <= 1'b0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            state_q     <= state_d;
            timer_q     <= timer_d;
            div_q       <= div_d;
            parity_en_q <= parity_en_d;
            two_stop_q  <= two_stop_d;
            par_q       <= par_d;
            shift_q     <= shift_d;
            bit_idx_q   <= bit_idx_d;
            stop_cnt_q  <= stop_cnt_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
        end
    end

endmodule
